// File: rtl/muldiv_seq.sv
// muldiv_seq: sequences MULT/MULTU/DIV/DIVU through iterative units and owns HI/LO.
module muldiv_seq #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        OpStart,
    input  logic [1:0]  OpSel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        MtHi,
    input  logic        MtLo,
    input  logic [31:0] WrData,
    output logic        Busy,
    output logic        Done,
    output logic        DivZeroExc,
    output logic        TimeoutExc,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut,
    output logic        MultIn,
    output logic        DivIn,
    output logic [31:0] UnitA,
    output logic [31:0] UnitB,
    input  logic        MultStop,
    input  logic        DivStop,
    input  logic [31:0] MultHigh,
    input  logic [31:0] MultLow,
    input  logic [31:0] DivHigh,
    input  logic [31:0] DivLow
);
    localparam int CW = $clog2(TIMEOUT + 1);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIX} state_t;
    state_t state, state_n;
    logic [1:0] op;
    logic sa, sb, dz, accept, sgn, div_zero, stop, tmo, mneg;
    logic [CW-1:0] cnt;
    logic [31:0] raw_hi, raw_lo, fix_hi, fix_lo;
    logic [63:0] prod, prod_n;
    // A divide-by-zero never leaves IDLE; dz alone makes that one cycle busy.
    assign accept     = state == IDLE && !dz && OpStart;
    assign sgn        = !OpSel[0];
    assign div_zero   = OpSel[1] && B == '0;
    assign stop       = op[1] ? DivStop : MultStop;
    assign tmo        = state == WAIT && !stop && cnt == CW'(TIMEOUT - 1);
    assign Busy       = state != IDLE || dz;
    assign Done       = dz || tmo || state == FIX;
    assign DivZeroExc = dz;
    assign TimeoutExc = tmo;
    assign MultIn     = state == ISSUE && !op[1];
    assign DivIn      = state == ISSUE && op[1];
    // sa/sb are latched as zero for unsigned ops, so no correction applies.
    assign mneg   = sa ^ sb;
    assign prod   = {raw_hi, raw_lo};
    assign prod_n = mneg ? -prod : prod;
    assign fix_hi = op[1] ? (sa ? -raw_hi : raw_hi) : prod_n[63:32];
    assign fix_lo = op[1] ? (mneg ? -raw_lo : raw_lo) : prod_n[31:0];
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept && !div_zero ? ISSUE : IDLE;
            ISSUE:   state_n = WAIT;
            WAIT:    state_n = stop ? FIX : tmo ? IDLE : WAIT;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (Reset) begin
            state  <= IDLE;
            dz     <= 1'b0;
            cnt    <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            raw_hi <= '0;
            raw_lo <= '0;
            UnitA  <= '0;
            UnitB  <= '0;
            HiOut  <= '0;
            LoOut  <= '0;
        end else begin
            state <= state_n;
            dz    <= accept && div_zero;
            cnt   <= state == WAIT ? cnt + 1'b1 : '0;
            if (accept) begin
                op    <= OpSel;
                sa    <= sgn && A[31];
                sb    <= sgn && B[31];
                UnitA <= sgn && A[31] ? -A : A;
                UnitB <= sgn && B[31] ? -B : B;
            end
            if (state == WAIT && stop) begin
                raw_hi <= op[1] ? DivHigh : MultHigh;
                raw_lo <= op[1] ? DivLow : MultLow;
            end
            if (state == FIX) begin
                HiOut <= fix_hi;
                LoOut <= fix_lo;
            end else if (state == IDLE && !dz) begin
                if (MtHi) HiOut <= WrData;
                if (MtLo) LoOut <= WrData;
            end
        end
    end
endmodule
